// File: rtl/bitsim_pkg.sv
// rtl/bitsim_pkg.sv - shared types and widths for the bit-serial datapath
// Purpose: mask/index widths, scheduler state enum and bitmask type.
// Ports: none (package).
package bitsim_pkg;
  localparam int MASK_W = 5;
  // Indices run 0..MASK_W-1, so $clog2(MASK_W) bits cover them (5 -> 3).
  localparam int IDX_W  = (MASK_W > 1) ? $clog2(MASK_W) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} sched_state_e;
  typedef logic [MASK_W-1:0] bitmask_t;
endpackage

// File: rtl/msb_prio_enc.sv
// rtl/msb_prio_enc.sv - MSB-first priority encoder
// Purpose: report the position of the highest set bit, counted from the MSB.
// Ports:
//   vec  in   W   input vector
//   idx  out  IW  0 for bit W-1 ... W-1 for bit 0; 0 when vec is empty
//   val  out  1   vec has at least one set bit
module msb_prio_enc #(
  parameter int W  = 5,
  parameter int IW = 3
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          val
);
  always_comb begin
    idx = '0;
    val = 1'b0;
    // Scan upward so the highest set bit is the last one written.
    for (int i = 0; i < W; i++) begin
      if (vec[i]) begin
        idx = IW'(W - 1 - i);
        val = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bit_serial_scheduler.sv
// rtl/bit_serial_scheduler.sv - emits set-bit positions of an operand mask, MSB-first
// Purpose: accept a nonzero-bit mask, then stream one beat per set bit to the PE;
//          an all-zero mask produces a single zero beat.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   flush                      sync abort of the current operand
//   in_valid/in_ready/in_bitmask   upstream mask handshake
//   out_valid/out_ready        downstream beat handshake
//   out_idx/out_last/out_zero  beat payload
//   busy                       operand in flight
module bit_serial_scheduler
  import bitsim_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MASK_W-1:0] in_bitmask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_zero,
  output logic             busy
);
  sched_state_e state_q, state_d;
  bitmask_t     residual_q, residual_d;
  logic         zero_q, zero_d;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_val;
  logic             run;
  logic             fire;
  logic             accept;
  bitmask_t         clr_mask;

  msb_prio_enc #(.W(MASK_W), .IW(IDX_W)) u_enc (
    .vec (residual_q),
    .idx (enc_idx),
    .val (enc_val)
  );

  assign run       = (state_q == RUN);
  assign busy      = run;
  assign out_valid = run;
  // IDLE drives a clean all-zero payload.
  assign out_idx   = run ? enc_idx : '0;
  // At most one bit left: r & (r-1) clears the lowest set bit.
  assign out_last  = run & ((residual_q & (residual_q - bitmask_t'(1))) == '0);
  assign out_zero  = run & zero_q;
  // Ready on the last fire too, so back-to-back operands have no bubble.
  assign in_ready  = !flush & (!run | (out_ready & out_last));

  assign fire     = out_valid & out_ready;
  assign accept   = in_valid & in_ready;
  assign clr_mask = bitmask_t'(1) << (MASK_W - 1 - int'(out_idx));

  always_comb begin
    state_d    = state_q;
    residual_d = residual_q;
    zero_d     = zero_q;
    if (fire) begin
      residual_d = residual_q & ~clr_mask;
      if (out_last) begin
        state_d = IDLE;
        zero_d  = 1'b0;
      end
    end
    if (accept) begin
      residual_d = in_bitmask;
      zero_d     = (in_bitmask == '0);
      state_d    = RUN;
    end
    if (flush) begin
      state_d    = IDLE;
      residual_d = '0;
      zero_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      residual_q <= '0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      residual_q <= residual_d;
      zero_q     <= zero_d;
    end
  end
endmodule
